// File: rtl/double_to_float.sv
// Narrowing FP conversion: IEEE-754 binary64 -> binary32 with round-to-nearest-even.
// Five-state handshake FSM (one operand in flight) raising invalid/overflow/underflow/inexact.
module double_to_float (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] double,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] float,
  output logic        nan_exception,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);
  localparam int unsigned EXP64_W  = 11;
  localparam int unsigned MANT64_W = 52;
  localparam int unsigned E_W      = 12;
  localparam int unsigned SHIFT_W  = 115;
  localparam int unsigned FLAG_W   = 4;
  localparam logic signed [E_W-1:0] EXP_ADJ = 12'sd896;

  typedef enum logic [2:0] {IDLE, CLASSIFY, ROUND, PACK, HOLD} state_t;
  typedef enum logic [2:0] {C_ZERO, C_DENORM, C_INF, C_QNAN, C_SNAN, C_HUGE, C_FINITE} cls_t;

  state_t                   state, state_nxt;
  cls_t                     cls, cls_nxt;
  logic                     sign, sign_nxt;
  logic [EXP64_W-1:0]       exp64, exp64_nxt;
  logic [MANT64_W-1:0]      mant64, mant64_nxt;
  logic signed [E_W-1:0]    e, e_nxt, e_calc;
  logic [31:0]              res, res_nxt, float_nxt;
  logic [FLAG_W-1:0]        flg, flg_nxt, flags_nxt;  // {nan, ovf, unf, inx}
  logic                     out_valid_nxt, in_ready_nxt;

  logic signed [E_W-1:0]    denorm_shift;
  logic [5:0]               shamt;
  logic [SHIFT_W-1:0]       wide;
  logic [22:0]              field;
  logic                     guard, sticky, rnd_up, rnd_inexact;
  logic [7:0]               exp_base;
  logic [30:0]              rounded;

  // Significand alignment and RNE; the hidden bit sits just above the kept window
  always_comb begin
    denorm_shift = 12'sd1 - e;
    shamt        = 6'd0;
    if (e <= 12'sd0)
      shamt = (denorm_shift > 12'sd63) ? 6'd63 : denorm_shift[5:0];
    wide        = SHIFT_W'({1'b1, mant64, 63'b0} >> shamt);
    field       = wide[114:92];
    guard       = wide[91];
    sticky      = |wide[90:0];
    rnd_up      = guard & (sticky | field[0]);
    rnd_inexact = guard | sticky;
    exp_base    = (e > 12'sd0) ? e[7:0] : 8'd0;
    rounded     = {exp_base, field} + 31'(rnd_up);
  end

  always_comb begin
    e_calc = $signed({1'b0, exp64}) - EXP_ADJ;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cls           <= C_ZERO;
      sign          <= 1'b0;
      exp64         <= '0;
      mant64        <= '0;
      e             <= '0;
      res           <= '0;
      flg           <= '0;
      float         <= '0;
      nan_exception <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      inexact       <= 1'b0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
    end else begin
      state         <= state_nxt;
      cls           <= cls_nxt;
      sign          <= sign_nxt;
      exp64         <= exp64_nxt;
      mant64        <= mant64_nxt;
      e             <= e_nxt;
      res           <= res_nxt;
      flg           <= flg_nxt;
      float         <= float_nxt;
      {nan_exception, overflow, underflow, inexact} <= flags_nxt;
      out_valid     <= out_valid_nxt;
      in_ready      <= in_ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = CLASSIFY;
      CLASSIFY: state_nxt = ROUND;
      ROUND:    state_nxt = PACK;
      PACK:     state_nxt = HOLD;
      HOLD:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cls_nxt    = cls;
    sign_nxt   = sign;
    exp64_nxt  = exp64;
    mant64_nxt = mant64;
    e_nxt      = e;
    res_nxt    = res;
    flg_nxt    = flg;
    float_nxt  = float;
    flags_nxt  = {nan_exception, overflow, underflow, inexact};
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt   = double[63];
          exp64_nxt  = double[62:52];
          mant64_nxt = double[51:0];
        end
      end
      CLASSIFY: begin
        e_nxt = e_calc;
        if (exp64 == '0)
          cls_nxt = (mant64 == '0) ? C_ZERO : C_DENORM;
        else if (exp64 == '1)
          cls_nxt = (mant64 == '0) ? C_INF : (mant64[51] ? C_QNAN : C_SNAN);
        else
          cls_nxt = (e_calc >= 12'sd255) ? C_HUGE : C_FINITE;
      end
      ROUND: begin
        res_nxt = {sign, 31'b0};
        flg_nxt = 4'b0000;
        case (cls)
          C_ZERO:   begin end
          C_DENORM: flg_nxt = 4'b0011;
          C_INF:    res_nxt = {sign, 8'hFF, 23'b0};
          C_QNAN:   res_nxt = {sign, 8'hFF, mant64[51:29]};
          C_SNAN: begin
            res_nxt = {sign, 8'hFF, 1'b1, mant64[50:29]};
            flg_nxt = 4'b1000;
          end
          C_HUGE: begin
            res_nxt = {sign, 8'hFF, 23'b0};
            flg_nxt = 4'b0101;
          end
          default: begin
            // A carry out of the fraction bumps the exponent; 255 means it overflowed
            if (rounded[30:23] == 8'hFF) begin
              res_nxt = {sign, 8'hFF, 23'b0};
              flg_nxt = 4'b0101;
            end else begin
              res_nxt = {sign, rounded};
              flg_nxt = {2'b00, (e <= 12'sd0) & rnd_inexact, rnd_inexact};
            end
          end
        endcase
      end
      PACK: begin
        float_nxt = res;
        flags_nxt = flg;
      end
      default: begin end
    endcase
    out_valid_nxt = (state_nxt == HOLD);
    in_ready_nxt  = (state_nxt == IDLE);
  end
endmodule

// File: tb/tb_double_to_float.sv
// Randomized scoreboard bench for double_to_float: expected results come from an
// exact-arithmetic rounding model; a monitor pops and compares on every output handshake.
module tb_double_to_float;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] double;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] float;
  logic        nan_exception, overflow, underflow, inexact;

  typedef struct packed {
    logic [63:0] d;
    logic [35:0] r;   // {float, nan, ovf, unf, inx}
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_item;
  sb_t dir [13];
  int  n_cmp = 0;
  int  n_err = 0;
  int  or_mode = 1;   // 0: out_ready low, 1: high, 2: random

  double_to_float dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .double(double),
    .out_valid(out_valid), .out_ready(out_ready), .float(float),
    .nan_exception(nan_exception), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got float=%h with nothing pending, required no output", float);
      end else begin
        mon_item = sb_q.pop_front();
        check($sformatf("result d=%h", mon_item.d),
              64'({float, nan_exception, overflow, underflow, inexact}), 64'(mon_item.r));
      end
    end
  end

  // Reference: value = sig * 2^lsb_e, rounded RNE to the float grid 2^q
  function automatic logic [35:0] model(input logic [63:0] d);
    logic s;
    logic [51:0] m;
    longint unsigned sig, n, rem, half;
    int ex, lsb_e, top, q, k, expf;
    logic inx, up;
    logic [31:0] bits;
    s  = d[63];
    ex = int'(d[62:52]);
    m  = d[51:0];
    if (ex == 2047) begin
      if (m == 0) return {s, 8'hFF, 23'd0, 4'b0000};
      if (m[51])  return {s, 8'hFF, m[51:29], 4'b0000};
      return {s, 8'hFF, 1'b1, m[50:29], 4'b1000};
    end
    sig   = (ex == 0) ? {12'd0, m} : {11'd0, 1'b1, m};
    lsb_e = (ex == 0) ? -1074 : ex - 1075;
    if (sig == 0) return {s, 31'd0, 4'b0000};
    top = lsb_e;
    for (int i = 63; i >= 0; i--) begin
      if (sig[i]) begin
        top = lsb_e + i;
        break;
      end
    end
    q   = (top - 23 > -149) ? top - 23 : -149;
    k   = q - lsb_e;
    up  = 1'b0;
    if (k >= 64) begin
      n   = 0;
      rem = sig;
    end else begin
      n    = sig >> k;
      rem  = sig & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      up   = (rem > half) || ((rem == half) && n[0]);
    end
    n = n + 64'(up);
    if (n == (64'd1 << 24)) begin
      n = 64'd1 << 23;
      q = q + 1;
    end
    inx = (rem != 0);
    if (n >= (64'd1 << 23)) begin
      expf = q + 150;
      if (expf >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
      bits = {s, 8'(expf), 23'(n - (64'd1 << 23))};
    end else begin
      bits = {s, 8'd0, 23'(n)};
    end
    return {bits, 1'b0, 1'b0, (top < -126) && inx, inx};
  endfunction

  function automatic logic [63:0] rand_double();
    logic [63:0] r;
    logic [10:0] ex;
    logic [51:0] m;
    r = {$urandom, $urandom};
    m = r[51:0];
    case ($urandom_range(0, 9))
      0, 1:    ex = 11'($urandom_range(1, 2046));
      2, 3:    ex = 11'($urandom_range(866, 930));
      4:       ex = 11'($urandom_range(1145, 1155));
      5:       ex = 11'd0;
      6:       ex = 11'h7FF;
      7:       ex = 11'($urandom_range(760, 880));
      default: ex = 11'($urandom_range(1000, 1050));
    endcase
    case ($urandom_range(0, 3))
      0:       m[28:0] = 29'h1000_0000;
      1:       m[51:29] = '1;
      default: begin end
    endcase
    return {r[63], ex, m};
  endfunction

  task automatic send(input logic [63:0] d, input logic [35:0] r);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    double   = d;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b for d=%h, required 1", in_ready, d);
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back({d, r});
    @(posedge clk); #1;
    // Junk while busy must be ignored
    in_valid = 1'($urandom_range(0, 1));
    double   = {$urandom, $urandom};
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 200 && sb_q.size() != 0; c++) @(negedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    bit ok;
    in_valid = 1'b0;
    double   = '0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_float", 64'(float), 64'd0);
    check("reset_flags", 64'({nan_exception, overflow, underflow, inexact}), 64'd0);
    reset = 1'b1;

    // Latency: accepting edge counts as edge 1, out_valid visible after edge 4
    @(posedge clk); #1;
    in_valid = 1'b1;
    double   = 64'h3FF0000000000000;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    sb_q.push_back({64'h3FF0000000000000, 32'h3F800000, 4'b0000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("latency_edge3_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_edge4_out_valid", 64'(out_valid), 64'd1);
    check("hold_in_ready", 64'(in_ready), 64'd0);

    dir[0]  = {64'h3FF0000000000000, 32'h3F800000, 4'b0000};
    dir[1]  = {64'h3FF0000010000000, 32'h3F800000, 4'b0001};
    dir[2]  = {64'h3FF0000030000000, 32'h3F800002, 4'b0001};
    dir[3]  = {64'h47F0000000000000, 32'h7F800000, 4'b0101};
    dir[4]  = {64'h47EFFFFFF0000000, 32'h7F800000, 4'b0101};
    dir[5]  = {64'hFFEFFFFFFFFFFFFF, 32'hFF800000, 4'b0101};
    dir[6]  = {64'h7FF4000000000001, 32'h7FE00000, 4'b1000};
    dir[7]  = {64'hFFF8000000000000, 32'hFFC00000, 4'b0000};
    dir[8]  = {64'h36A0000000000000, 32'h00000001, 4'b0000};
    dir[9]  = {64'h3690000000000000, 32'h00000000, 4'b0011};
    dir[10] = {64'h0000000000000001, 32'h00000000, 4'b0011};
    dir[11] = {64'hFFF0000000000000, 32'hFF800000, 4'b0000};
    dir[12] = {64'h8000000000000000, 32'h80000000, 4'b0000};
    foreach (dir[i]) begin
      check($sformatf("model d=%h", dir[i].d), 64'(model(dir[i].d)), 64'(dir[i].r));
      send(dir[i].d, dir[i].r);
    end
    drain();

    // Backpressure: result held stable, busy, further operands ignored
    or_mode = 0;
    @(posedge clk);
    send(64'h3FF8000000000000, {32'h3FC00000, 4'b0000});
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("hold_reached", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      double   = 64'h4000000000000000;
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_float", 64'(float), 64'h3FC00000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    or_mode  = 1;
    repeat (12) @(negedge clk);
    check("stall_drained", 64'(sb_q.size()), 64'd0);
    check("no_second_accept", 64'(out_valid), 64'd0);
    check("back_to_idle", 64'(in_ready), 64'd1);

    // Reset while in ROUND with nonzero outputs from the previous result
    send(64'h47F0000000000000, {32'h7F800000, 4'b0101});
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1;
    double   = 64'h3FF0000000000000;
    @(negedge clk);
    check("pre_reset_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_flags", 64'({nan_exception, overflow, underflow, inexact}), 64'd0);
    check("midreset_float", 64'(float), 64'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_quiet", 64'(out_valid), 64'd0);

    // Random operands with random backpressure
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      d = rand_double();
      send(d, model(d));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
